button_debounce: RTL and testbench
==================================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter WIDTH, default 8, number of independent button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz), consecutive stable cycles required to accept a new level.
REQ-003 Parameter ACTIVE_LOW, default 1, raw pins read 0 when pressed.
REQ-004 clk  input  1  single system clock; all state on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 btn_raw  input  WIDTH  asynchronous, bouncing button pins.
REQ-007 btn_level  output  WIDTH  debounced level, 1 = pressed; drives the 8-bit PIO input port.
REQ-008 btn_press  output  WIDTH  one-cycle pulse per channel on accepted press.
REQ-009 btn_release  output  WIDTH  one-cycle pulse per channel on accepted release.

Function
REQ-010 Each channel SHALL pass btn_raw through a two-flop synchronizer; the second flop output is the sampled value s.
REQ-011 s SHALL be normalized to pressed=1 (inverted when ACTIVE_LOW=1) before debouncing.
REQ-012 Each channel SHALL hold a counter of width clog2(DEBOUNCE_CYCLES), unsigned, never wrapping.
REQ-013 When s equals btn_level, the counter SHALL clear to 0 on that edge.
REQ-014 When s differs from btn_level and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment.
REQ-015 When s differs from btn_level and counter == DEBOUNCE_CYCLES-1, btn_level SHALL toggle and the counter SHALL clear on the same edge.
REQ-016 A raw change held stable from before edge t SHALL appear on btn_level at edge t+1+DEBOUNCE_CYCLES (2 synchronizer edges plus DEBOUNCE_CYCLES-1 counting edges).
REQ-017 Any reversion of s before the counter reaches terminal SHALL discard the count (glitch rejection); no partial credit.
REQ-018 btn_press SHALL be registered high for exactly the one cycle following a 0->1 btn_level transition edge, i.e. aligned with the first cycle btn_level is 1; btn_release likewise for 1->0.
REQ-019 btn_press and btn_release SHALL never be high simultaneously on one channel.
REQ-020 Channels SHALL operate independently; simultaneous transitions on several channels SHALL all be reported in the same cycle.
REQ-021 DEBOUNCE_CYCLES < 2 SHALL be rejected at elaboration.

Reset
REQ-022 Reset SHALL force synchronizer flops to the released raw level (all 1s when ACTIVE_LOW=1).
REQ-023 Reset SHALL force btn_level, btn_press, btn_release to 0 and all counters to 0.
REQ-024 Reset asserted mid-count SHALL abandon the count; after deassertion a held press SHALL need the full REQ-016 latency again.
REQ-025 No pulse SHALL be emitted as a consequence of reset assertion or deassertion.

Structure
REQ-026 Shared package btn_pkg SHALL hold DEBOUNCE_CYCLES default, clock-frequency constant and the counter-width function.
REQ-027 Per-channel logic (sync, counter, level, pulses) SHALL be a sub-module debounce_channel, instantiated WIDTH times by generate.

Verification (DEBOUNCE_CYCLES=4, WIDTH=8, ACTIVE_LOW=1)
REQ-028 btn_raw[0] 1->0 before edge 10, held -> btn_level[0]=1 from edge 15; btn_press[0]=1 for that single cycle only.
REQ-029 btn_raw[3] low for 3 cycles then high -> btn_level[3] stays 0, no pulses.
REQ-030 Pressed channel 0 released and held -> btn_level[0]=0 after 5 edges, btn_release[0] single-cycle pulse.
REQ-031 btn_raw=8'h00 in one cycle -> btn_level=8'hFF in one cycle, btn_press=8'hFF for one cycle.
REQ-032 Reset asserted 2 edges into a count while press held -> outputs 0 at once; after release of reset btn_level rises exactly 5 edges later, no pulse at reset.
REQ-033 Raw toggling every cycle for 100 cycles -> btn_level, btn_press, btn_release constant 0.

Source files
------------

// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared constants and counter sizing for the button debouncer
package btn_pkg;

    localparam int CLK_FREQ_HZ             = 50_000_000;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500_000;

    // Smallest width able to hold 0 .. cycles-1, never below one bit.
    function automatic int cnt_width(input int cycles);
        int w;
        w = 1;
        while ((64'd1 << w) < 64'(cycles)) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/button_debounce_if.sv
// rtl/button_debounce_if.sv - raw pin input and debounced level/pulse outputs
interface button_debounce_if #(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0] btn_raw;
    logic [WIDTH-1:0] btn_level;
    logic [WIDTH-1:0] btn_press;
    logic [WIDTH-1:0] btn_release;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release
    );

endinterface

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button: two-flop sync, stability counter, level and edge pulses
module debounce_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERMINAL = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic          IDLE_RAW = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
        $error("DEBOUNCE_CYCLES must be at least 2");
    end

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;
    logic          r_release;

    logic w_pressed;
    logic w_differ;
    logic w_terminal;

    assign w_pressed  = r_sync2 ^ IDLE_RAW;
    assign w_differ   = w_pressed != r_level;
    assign w_terminal = r_cnt == TERMINAL;

    // Pulses are registered on the toggle edge so they line up with the new level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1   <= IDLE_RAW;
            r_sync2   <= IDLE_RAW;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= i_raw;
            r_sync2   <= r_sync1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (!w_terminal) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt     <= '0;
                r_level   <= ~r_level;
                r_press   <= ~r_level;
                r_release <= r_level;
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - WIDTH independent debounced button channels
module button_debounce
    import btn_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic               clk,
    input  logic               reset,
    button_debounce_if.slave   bus
);

    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_press;
    logic [WIDTH-1:0] w_release;

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .i_raw     (bus.btn_raw[g]),
            .o_level   (w_level[g]),
            .o_press   (w_press[g]),
            .o_release (w_release[g])
        );
    end

    assign bus.btn_level   = w_level;
    assign bus.btn_press   = w_press;
    assign bus.btn_release = w_release;

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - vector table and scoreboard bench, DEBOUNCE_CYCLES=4, WIDTH=8, active-low pins
module tb_button_debounce;

    typedef struct {
        logic       rst;
        logic [7:0] raw;
        logic [7:0] lvl;
        logic [7:0] prs;
        logic [7:0] rel;
    } vec_t;

    typedef struct {
        int         idx;
        logic [7:0] lvl;
        logic [7:0] prs;
        logic [7:0] rel;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    button_debounce_if #(.WIDTH(8)) bus ();

    button_debounce #(
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (4),
        .ACTIVE_LOW      (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   step_no = 0;

    function automatic void add(input logic rst, input logic [7:0] raw,
                                input logic [7:0] lvl, input logic [7:0] prs,
                                input logic [7:0] rel);
        vec_t v;
        v.rst = rst; v.raw = raw; v.lvl = lvl; v.prs = prs; v.rel = rel;
        vecs.push_back(v);
    endfunction

    function automatic void add_n(input int n, input logic rst, input logic [7:0] raw,
                                  input logic [7:0] lvl, input logic [7:0] prs,
                                  input logic [7:0] rel);
        for (int k = 0; k < n; k++) add(rst, raw, lvl, prs, rel);
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [7:0] act, input logic [7:0] want);
        n_total++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, act, want);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(input logic rst, input logic [7:0] raw,
                        input logic [7:0] lvl, input logic [7:0] prs,
                        input logic [7:0] rel);
        exp_t e;
        reset       = rst;
        bus.btn_raw = raw;
        e.idx = step_no; e.lvl = lvl; e.prs = prs; e.rel = rel;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("level",   e.idx, bus.btn_level,   e.lvl);
        check("press",   e.idx, bus.btn_press,   e.prs);
        check("release", e.idx, bus.btn_release, e.rel);
        check("press_and_release", e.idx, bus.btn_press & bus.btn_release, 8'h00);
        step_no++;
    endtask

    initial begin
        bus.btn_raw = 8'hFF;

        add_n(2, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h00);
        add_n(2, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h00);
        // ch0 press: raw change before step 4 shows at step 9
        add_n(5, 1'b0, 8'hFE, 8'h00, 8'h00, 8'h00);
        add  (   1'b0, 8'hFE, 8'h01, 8'h01, 8'h00);
        add_n(2, 1'b0, 8'hFE, 8'h01, 8'h00, 8'h00);
        // ch3 low for only three cycles is rejected
        add_n(3, 1'b0, 8'hF6, 8'h01, 8'h00, 8'h00);
        add_n(4, 1'b0, 8'hFE, 8'h01, 8'h00, 8'h00);
        // ch0 release
        add_n(5, 1'b0, 8'hFF, 8'h01, 8'h00, 8'h00);
        add  (   1'b0, 8'hFF, 8'h00, 8'h00, 8'h01);
        add_n(2, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h00);
        // all channels together
        add_n(5, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        add  (   1'b0, 8'h00, 8'hFF, 8'hFF, 8'h00);
        add_n(2, 1'b0, 8'h00, 8'hFF, 8'h00, 8'h00);
        add_n(5, 1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00);
        add  (   1'b0, 8'hFF, 8'h00, 8'h00, 8'hFF);
        add  (   1'b0, 8'hFF, 8'h00, 8'h00, 8'h00);
        // reset two counting edges into a held press, then full latency again
        add_n(4, 1'b0, 8'hFE, 8'h00, 8'h00, 8'h00);
        add_n(2, 1'b1, 8'hFE, 8'h00, 8'h00, 8'h00);
        add_n(5, 1'b0, 8'hFE, 8'h00, 8'h00, 8'h00);
        add  (   1'b0, 8'hFE, 8'h01, 8'h01, 8'h00);
        add  (   1'b0, 8'hFE, 8'h01, 8'h00, 8'h00);
        add_n(5, 1'b0, 8'hFF, 8'h01, 8'h00, 8'h00);
        add  (   1'b0, 8'hFF, 8'h00, 8'h00, 8'h01);
        add  (   1'b0, 8'hFF, 8'h00, 8'h00, 8'h00);
        // raw chatter every cycle never settles
        for (int i = 0; i < 100; i++)
            add(1'b0, (i % 2 == 1) ? 8'hFF : 8'h00, 8'h00, 8'h00, 8'h00);
        add_n(6, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h00);

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].rst, vecs[i].raw, vecs[i].lvl, vecs[i].prs, vecs[i].rel);

        // ch7 press, then async reset clears outputs without waiting for an edge
        for (int i = 0; i < 5; i++) step(1'b0, 8'h7F, 8'h00, 8'h00, 8'h00);
        step(1'b0, 8'h7F, 8'h80, 8'h80, 8'h00);
        reset = 1'b1;
        #1;
        check("async_reset_level", step_no, bus.btn_level, 8'h00);
        check("async_reset_press", step_no, bus.btn_press, 8'h00);
        check("async_reset_release", step_no, bus.btn_release, 8'h00);
        step(1'b1, 8'h7F, 8'h00, 8'h00, 8'h00);
        step(1'b1, 8'h7F, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h7F, 8'h00, 8'h00, 8'h00);
        step(1'b0, 8'h7F, 8'h80, 8'h80, 8'h00);
        step(1'b0, 8'h7F, 8'h80, 8'h00, 8'h00);

        n_total++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
